// File: rtl/r2sdf_stage.sv
// r2sdf_stage: radix-2 single-delay-feedback decimation-in-frequency butterfly.
//
// Each frame is 2*DEPTH accepted samples. The first DEPTH samples (phase 0)
// are stored in the feedback delay. Each of the next DEPTH samples (phase 1) is
// combined with the stored sample from DEPTH steps earlier. The sum is output
// and the difference is written back into the delay. The stored differences
// leave during the next frame's phase 0, or during a flush, and are tagged
// with a twiddle index so that a downstream rotator can apply W^k.
//
// Ports:
//   iClk, iRst_n           clock, asynchronous active-low reset
//   iData_valid            input sample present (stalls allowed)
//   iData_Re / iData_Im    WIDTH-bit two's complement input sample
//   iFlush                 drain stored differences (frame boundary only)
//   oReady                 low while flushing; input is dropped then
//   oData_valid            output sample valid
//   oData_Re / oData_Im    OW-bit output sample, zero when not valid
//   oTw_en / oTw_idx       difference term and its twiddle index k
module r2sdf_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int SCALE = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int OW = (SCALE != 0) ? WIDTH : WIDTH + 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iData_valid,
  input  logic [WIDTH-1:0] iData_Re,
  input  logic [WIDTH-1:0] iData_Im,
  input  logic             iFlush,
  output logic             oReady,
  output logic             oData_valid,
  output logic [OW-1:0]    oData_Re,
  output logic [OW-1:0]    oData_Im,
  output logic             oTw_en,
  output logic [AW-1:0]    oTw_idx
);

  localparam int XW = WIDTH + 1;

  // Optional halving with round-half-up: (v + 1) >>> 1.
  function automatic logic [OW-1:0] scale_out(input logic [XW-1:0] v);
    logic [XW:0] t;
    t = {v[XW-1], v} + {{XW{1'b0}}, 1'b1};
    if (SCALE != 0) begin
      scale_out = t[OW:1];
    end else begin
      scale_out = v[OW-1:0];
    end
  endfunction

  logic [AW:0]   r_cnt;
  logic          r_primed;
  logic          r_ready;
  logic [XW-1:0] r_buf_re [DEPTH];
  logic [XW-1:0] r_buf_im [DEPTH];
  logic          r_valid;
  logic [OW-1:0] r_re;
  logic [OW-1:0] r_im;
  logic          r_tw_en;
  logic [AW-1:0] r_tw_idx;

  logic          w_step;
  logic          w_phase;
  logic [AW-1:0] w_k;
  logic          w_last_k;
  logic          w_flush_start;
  logic [XW-1:0] w_x_re, w_x_im;
  logic [XW-1:0] w_sum_re, w_sum_im;
  logic [XW-1:0] w_diff_re, w_diff_im;
  logic [XW-1:0] w_in_re, w_in_im;
  logic [XW-1:0] w_out_re, w_out_im;
  logic          w_out_valid;

  // While flushing (r_ready low), every cycle is a step and input is ignored.
  assign w_step        = (iData_valid & r_ready) | ~r_ready;
  assign w_phase       = r_cnt[AW];
  assign w_k           = r_cnt[AW-1:0];
  assign w_last_k      = (w_k == {AW{1'b1}});
  // Data in the same cycle wins over a flush request.
  assign w_flush_start = r_ready & ~iData_valid & iFlush & r_primed &
                         (r_cnt == {(AW+1){1'b0}});

  // Butterfly datapath: sign-extended input (zero while flushing), sum/difference with delay head.
  always_comb begin
    w_x_re      = r_ready ? {iData_Re[WIDTH-1], iData_Re} : {XW{1'b0}};
    w_x_im      = r_ready ? {iData_Im[WIDTH-1], iData_Im} : {XW{1'b0}};
    w_sum_re    = r_buf_re[DEPTH-1] + w_x_re;
    w_sum_im    = r_buf_im[DEPTH-1] + w_x_im;
    w_diff_re   = r_buf_re[DEPTH-1] - w_x_re;
    w_diff_im   = r_buf_im[DEPTH-1] - w_x_im;
    w_in_re     = w_x_re;
    w_in_im     = w_x_im;
    w_out_re    = r_buf_re[DEPTH-1];
    w_out_im    = r_buf_im[DEPTH-1];
    w_out_valid = 1'b0;
    if (w_phase) begin
      w_in_re     = w_diff_re;
      w_in_im     = w_diff_im;
      w_out_re    = w_sum_re;
      w_out_im    = w_sum_im;
      w_out_valid = w_step;
    end else begin
      // The head is a stored difference only once a full frame has completed.
      w_out_valid = w_step & r_primed;
    end
  end

  // Feedback delay line; contents survive reset since r_primed masks stale data.
  always_ff @(posedge iClk) begin
    if (w_step) begin
      r_buf_re[0] <= w_in_re;
      r_buf_im[0] <= w_in_im;
      for (int i = 1; i < DEPTH; i++) begin
        r_buf_re[i] <= r_buf_re[i-1];
        r_buf_im[i] <= r_buf_im[i-1];
      end
    end
  end

  // Frame counter, primed flag and flush control.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cnt    <= {(AW+1){1'b0}};
      r_primed <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      if (w_step) begin
        if (!r_ready && w_last_k) begin
          r_cnt   <= {(AW+1){1'b0}};
          r_ready <= 1'b1;
        end else begin
          r_cnt <= r_cnt + {{AW{1'b0}}, 1'b1};
        end
        // End of phase 1 leaves differences in the delay; end of phase 0 does not.
        if (w_last_k) begin
          r_primed <= w_phase;
        end
      end else if (w_flush_start) begin
        r_ready <= 1'b0;
      end
    end
  end

  // Registered outputs, forced to zero when not valid.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_valid  <= 1'b0;
      r_re     <= {OW{1'b0}};
      r_im     <= {OW{1'b0}};
      r_tw_en  <= 1'b0;
      r_tw_idx <= {AW{1'b0}};
    end else begin
      r_valid  <= w_out_valid;
      r_re     <= w_out_valid ? scale_out(w_out_re) : {OW{1'b0}};
      r_im     <= w_out_valid ? scale_out(w_out_im) : {OW{1'b0}};
      r_tw_en  <= w_out_valid & ~w_phase;
      r_tw_idx <= (w_out_valid & ~w_phase) ? w_k : {AW{1'b0}};
    end
  end

  assign oReady      = r_ready;
  assign oData_valid = r_valid;
  assign oData_Re    = r_re;
  assign oData_Im    = r_im;
  assign oTw_en      = r_tw_en;
  assign oTw_idx     = r_tw_idx;

endmodule
